mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration in cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration in cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 asserts).
REQ-005 SHALL have port start  input  1  operation strobe from E stage, sampled at posedge clk.
REQ-006 SHALL have port md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-007 SHALL have port rs_d  input  32  first operand: multiplicand/dividend/mthi/mtlo source.
REQ-008 SHALL have port rt_d  input  32  second operand: multiplier/divisor.
REQ-009 SHALL have port busy  output  1  high while a mult/div is in flight.
REQ-010 SHALL have port md_out  output  32  mfhi/mflo read data, fed to the pipeline md path.
REQ-011 SHALL have ports hi_out, lo_out  output  32 each  current architectural HI/LO.

Function
REQ-012 SHALL accept an operation only at a posedge where start=1 and busy=0; start while busy=1 SHALL be ignored, with no state change.
REQ-013 On accepted mult/multu (cycle T): SHALL capture rs_d, rt_d; busy=1 in cycles T+1..T+MULT_CYCLES; HI/LO SHALL commit at the edge ending T+MULT_CYCLES; busy=0 and new HI/LO visible from T+MULT_CYCLES+1.
REQ-014 div/divu SHALL follow REQ-013 with DIV_CYCLES.
REQ-015 mult: signed 32x32->64, HI=[63:32], LO=[31:0]; multu: unsigned.
REQ-016 div: LO=quotient truncated toward zero, HI=remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-017 Divisor 0 (div or divu): SHALL run full DIV_CYCLES busy period and leave HI/LO unchanged.
REQ-018 div 0x80000000 / 0xFFFFFFFF: SHALL yield LO=0x80000000, HI=0x00000000.
REQ-019 Pending result SHALL be held internally; HI/LO SHALL NOT change during busy.
REQ-020 mthi/mtlo with start=1, busy=0: HI (resp. LO) <= rs_d at that edge, busy stays 0; ignored while busy.
REQ-021 md_out SHALL be combinational: HI when md_op=5, LO when md_op=6, else 0; independent of start; reads pre-commit value while busy.
REQ-022 Busy counter SHALL be internal, loaded with cycle count on accept, decremented each edge, commit at count 1->0; no wrap.
REQ-023 Two-state control: IDLE (busy=0) -> RUN on accepted mult/div; RUN -> IDLE at commit edge; a start at the commit edge is ignored (busy=1 then).
REQ-024 Operand inputs SHALL be don't-care after the accept edge.

Reset
REQ-025 reset=0 SHALL immediately (asynchronously) clear HI, LO, counter, pending result; busy=0, state IDLE.
REQ-026 Reset during RUN SHALL abort the operation; no commit occurs after release.
REQ-027 After reset release, first accepted operation SHALL occur no earlier than the next posedge.

Verification
REQ-028 mult rs=0xFFFFFFFE, rt=3, start 1 cycle -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 div rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu rs=7, rt=0 -> busy 10 cycles, HI/LO unchanged.
REQ-031 mthi rs=0x12345678 then md_op=5 -> md_out=0x12345678 next cycle, busy never asserted; mtlo issued while busy -> LO unchanged.
REQ-032 div started, reset=0 pulsed mid-count (cycle 4) -> busy, HI, LO 0 immediately; no update after 10 cycles.
REQ-033 start with mult while busy from prior div -> ignored; only div result commits, busy drops after 10 cycles.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit with mfhi/mflo/mthi/mtlo
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_d,
  input  logic [31:0] rt_d,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_MULT_LD = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_LD  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_count;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic [31:0]         r_pend_hi;
  logic [31:0]         r_pend_lo;
  logic                r_pend_wr;

  logic        w_is_mult;
  logic        w_is_div;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_div_signed;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_uquo;
  logic [31:0] w_urem;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_is_mult = (md_op == 4'd1) || (md_op == 4'd2);
  assign w_is_div  = (md_op == 4'd3) || (md_op == 4'd4);

  // Sign-extending to 64 bits lets one 64-bit product serve mult and multu.
  assign w_a_ext = {{32{(md_op == 4'd1) & rs_d[31]}}, rs_d};
  assign w_b_ext = {{32{(md_op == 4'd1) & rt_d[31]}}, rt_d};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_div_signed = (md_op == 4'd3);
  assign w_neg_a      = w_div_signed & rs_d[31];
  assign w_neg_b      = w_div_signed & rt_d[31];
  assign w_mag_a      = w_neg_a ? (~rs_d + 32'd1) : rs_d;
  assign w_mag_b      = (rt_d == 32'd0) ? 32'd1 : (w_neg_b ? (~rt_d + 32'd1) : rt_d);
  assign w_uquo       = w_mag_a / w_mag_b;
  assign w_urem       = w_mag_a % w_mag_b;
  assign w_quo        = (w_neg_a ^ w_neg_b) ? (~w_uquo + 32'd1) : w_uquo;
  assign w_rem        = w_neg_a ? (~w_urem + 32'd1) : w_urem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_is_mult) begin
              r_pend_hi <= w_prod[63:32];
              r_pend_lo <= w_prod[31:0];
              r_pend_wr <= 1'b1;
              r_count   <= c_MULT_LD;
              r_state   <= RUN;
            end else if (w_is_div) begin
              r_pend_hi <= w_rem;
              r_pend_lo <= w_quo;
              r_pend_wr <= (rt_d != 32'd0);
              r_count   <= c_DIV_LD;
              r_state   <= RUN;
            end else if (md_op == 4'd7) begin
              r_hi <= rs_d;
            end else if (md_op == 4'd8) begin
              r_lo <= rs_d;
            end
          end
        end
        RUN: begin
          if (r_count == c_ONE) begin
            r_state <= IDLE;
            r_count <= '0;
            if (r_pend_wr) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
          end else if (r_count != '0) begin
            r_count <= r_count - c_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = (r_state == RUN);
  assign hi_out = r_hi;
  assign lo_out = r_lo;

  always_comb begin
    md_out = 32'd0;
    case (md_op)
      4'd5:    md_out = r_hi;
      4'd6:    md_out = r_lo;
      default: md_out = 32'd0;
    endcase
  end

endmodule
`default_nettype wire
